// File: rtl/pipe_if_stage.sv
// ---------------------------------------------------------------------------
// pipe_if_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the five-stage
// pipelined MIPS core. The stage owns the fetch PC, requests instruction
// words from instruction memory over a simple ready handshake, and picks the
// next PC from the decode stage's pcsource selector. The fetched word and its
// PC+4 go into the IF/ID register for the decode stage.
//
// The architecture keeps the one-instruction branch delay slot. When decode
// redirects, the word being fetched in that cycle is the delay slot and is
// always kept. If that fetch has not completed yet, the redirect target is
// parked in pend_pc until the delay-slot fetch lands.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   wpcir       1 = PC and IF/ID may update, 0 = load-use stall (hold all)
//   pcsource    00 pc+4, 01 branch (bpc), 10 jr (rpc), 11 j/jal (jpc)
//   bpc         branch target from decode
//   rpc         register (jr) target from decode
//   jpc         jump target from decode
//   imem_rdata  instruction word, valid when imem_ready = 1
//   imem_ready  fetch completes this cycle
//   imem_req    fetch request (combinational)
//   imem_addr   fetch address, always equal to pc (combinational)
//   pc          current fetch PC
//   dpc4        IF/ID: PC+4 of the instruction in decode
//   dinst       IF/ID: instruction in decode
//   dvalid      IF/ID: 1 = dinst is real, 0 = bubble
// ---------------------------------------------------------------------------
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid
);

    // FETCH: normal sequencing. PENDING: a redirect has been accepted but the
    // delay-slot fetch is still outstanding; pend_pc holds the target.
    typedef enum logic {
        FETCH   = 1'b0,
        PENDING = 1'b1
    } if_state_t;

    if_state_t   state;
    logic [31:0] pend_pc;

    logic [31:0] pc_plus4;
    logic        fire;
    logic        redir;
    logic [31:0] redir_raw;
    logic [31:0] redir_target;

    // Request whenever the pipeline is allowed to advance and we are not held
    // in reset; the address is simply the architectural PC.
    assign imem_req  = wpcir & ~reset;
    assign imem_addr = pc;

    // Modulo-2^32 increment, so the top word wraps back to address zero.
    assign pc_plus4 = pc + 32'd4;

    assign fire = imem_req & imem_ready;

    // Only a real instruction in decode may redirect; a bubble carries no
    // meaningful pcsource. A stalled pipe redirects nothing either.
    assign redir = dvalid & (pcsource != 2'b00) & wpcir;

    // Target selection from the decode-stage control. The low two bits are
    // cleared so an unaligned jr register value still lands on a word.
    always_comb begin
        redir_raw = pc_plus4;
        unique case (pcsource)
            2'b01:   redir_raw = bpc;
            2'b10:   redir_raw = rpc;
            2'b11:   redir_raw = jpc;
            default: redir_raw = pc_plus4;
        endcase
        redir_target = {redir_raw[31:2], 2'b00};
    end

    // Sequencing of PC, IF/ID register and the pending-redirect FSM.
    // A completed fetch always enters IF/ID (it is either the next sequential
    // instruction or the delay slot). An incomplete fetch puts a bubble into
    // IF/ID while the PC holds. With wpcir low every register holds and the
    // memory response is ignored, since no request was issued.
    // In PENDING a new redirect could only come from a control transfer in a
    // delay slot, which is undefined; the parked target wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            pend_pc <= 32'h0000_0000;
            dpc4    <= 32'h0000_0000;
            dinst   <= NOP_INST;
            dvalid  <= 1'b0;
        end else if (wpcir) begin
            if (fire) begin
                dpc4   <= pc_plus4;
                dinst  <= imem_rdata;
                dvalid <= 1'b1;
            end else begin
                dinst  <= NOP_INST;
                dvalid <= 1'b0;
            end

            unique case (state)
                FETCH: begin
                    if (fire) begin
                        pc <= redir ? redir_target : pc_plus4;
                    end else if (redir) begin
                        pend_pc <= redir_target;
                        state   <= PENDING;
                    end
                end
                PENDING: begin
                    if (fire) begin
                        pc    <= pend_pc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_if_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_if_stage
//
// Self-checking bench for pipe_if_stage. A behavioural reference model keeps
// the fetch PC, the IF/ID contents and a queue of parked redirect targets,
// and is advanced once per clock from the same inputs that drive the DUT.
// Instruction memory is a fixed function of the address. Directed sequences
// walk through the main scenarios, then a randomized run follows.
// ---------------------------------------------------------------------------
module tb_pipe_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic [31:0] dinst;
    logic        dvalid;

    int checkCount;
    int failCount;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_dpc4;
    logic [31:0] m_dinst;
    logic        m_dvalid;
    logic [31:0] parkedQ[$];

    pipe_if_stage #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wpcir      (wpcir),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .dpc4       (dpc4),
        .dinst      (dinst),
        .dvalid     (dvalid)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Contents of instruction memory: distinct, nonzero word per address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[15:0] ^ 16'h5A5A, ~addr[15:0]};
    endfunction

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_pc     = RESET_PC;
        m_dpc4   = 32'h0;
        m_dinst  = NOP_INST;
        m_dvalid = 1'b0;
        parkedQ.delete();
    endtask

    // One clock of the reference model, derived from the stage rules:
    // a completed fetch enters IF/ID, a missed fetch inserts a bubble, a
    // redirect either goes straight to the PC or is parked until the
    // delay-slot fetch completes, and a stall changes nothing.
    task automatic modelStep();
        logic        fire;
        logic        redir;
        logic [31:0] tgt;
        fire  = wpcir && imem_ready;
        redir = m_dvalid && (pcsource != 2'b00) && wpcir;
        case (pcsource)
            2'b01:   tgt = bpc;
            2'b10:   tgt = rpc;
            default: tgt = jpc;
        endcase
        tgt = tgt & 32'hFFFF_FFFC;
        if (wpcir) begin
            if (fire) begin
                m_dpc4   = m_pc + 32'd4;
                m_dinst  = imem_rdata;
                m_dvalid = 1'b1;
                if (parkedQ.size() != 0) m_pc = parkedQ.pop_front();
                else if (redir)          m_pc = tgt;
                else                     m_pc = m_pc + 32'd4;
            end else begin
                m_dinst  = NOP_INST;
                m_dvalid = 1'b0;
                if (redir && parkedQ.size() == 0) parkedQ.push_back(tgt);
            end
        end
    endtask

    task automatic checkAgainstModel();
        checkOutput("imem_req", {31'b0, imem_req}, {31'b0, wpcir & ~reset});
        checkOutput("imem_addr", imem_addr, m_pc);
        checkOutput("pc", pc, m_pc);
        checkOutput("dpc4", dpc4, m_dpc4);
        checkOutput("dinst", dinst, m_dinst);
        checkOutput("dvalid", {31'b0, dvalid}, {31'b0, m_dvalid});
    endtask

    // Drives one cycle of inputs at the falling edge, checks the DUT against
    // the model, advances the model, and returns just after the rising edge
    // so callers can inspect the freshly registered state.
    task automatic applyStimulus(input logic wp, input logic [1:0] ps,
                                 input logic [31:0] b, input logic [31:0] r,
                                 input logic [31:0] j, input logic rdy);
        @(negedge clock);
        wpcir      = wp;
        pcsource   = ps;
        bpc        = b;
        rpc        = r;
        jpc        = j;
        imem_ready = rdy;
        imem_rdata = memWord(m_pc);
        #1;
        checkAgainstModel();
        modelStep();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        reset      = 1'b1;
        wpcir      = 1'b1;
        pcsource   = 2'b00;
        bpc        = 32'h0;
        rpc        = 32'h0;
        jpc        = 32'h0;
        imem_rdata = 32'h0;
        imem_ready = 1'b1;
        modelReset();

        // Reset values, with wpcir high: no request while reset is asserted.
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_dpc4", dpc4, 32'h0);
        checkOutput("rst_dinst", dinst, NOP_INST);
        checkOutput("rst_dvalid", {31'b0, dvalid}, 32'h0);
        reset = 1'b0;

        // Straight-line fetch: 0,4,8,C.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
            checkOutput("seq_pc", pc, 32'(4 * (i + 1)));
            checkOutput("seq_dpc4", dpc4, 32'(4 * (i + 1)));
            checkOutput("seq_dvalid", {31'b0, dvalid}, 32'h1);
        end

        // Taken branch while fetching 0x10: delay slot kept, then 0x40, 0x44.
        applyStimulus(1'b1, 2'b01, 32'h40, 32'h0, 32'h0, 1'b1);
        checkOutput("beq_pc", pc, 32'h40);
        checkOutput("beq_slot", dinst, memWord(32'h10));
        checkOutput("beq_slot_v", {31'b0, dvalid}, 32'h1);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("beq_next", pc, 32'h44);

        // Memory stall for 3 cycles at 0x44: bubbles, PC holds.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
            checkOutput("stall_pc", pc, 32'h44);
            checkOutput("stall_dinst", dinst, NOP_INST);
            checkOutput("stall_dvalid", {31'b0, dvalid}, 32'h0);
        end
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("stall_done_dpc4", dpc4, 32'h48);

        // jr to an unaligned register value while the fetch at 0x48 stalls.
        applyStimulus(1'b1, 2'b10, 32'h0, 32'h103, 32'h0, 1'b0);
        checkOutput("jr_bubble", {31'b0, dvalid}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 2'b10, 32'h0, 32'h777, 32'h0, 1'b0);
            checkOutput("jr_hold_pc", pc, 32'h48);
        end
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("jr_slot", dinst, memWord(32'h48));
        checkOutput("jr_target", pc, 32'h100);

        // Load-use stall with a jump in decode: nothing moves.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 2'b11, 32'h0, 32'h0, 32'h200, 1'b1);
            checkOutput("wp_pc", pc, 32'h100);
            checkOutput("wp_dinst", dinst, memWord(32'h48));
            checkOutput("wp_dvalid", {31'b0, dvalid}, 32'h1);
        end
        applyStimulus(1'b1, 2'b11, 32'h0, 32'h0, 32'h200, 1'b1);
        checkOutput("wp_release_pc", pc, 32'h200);
        checkOutput("wp_release_dpc4", dpc4, 32'h104);

        // Jump to the top word, then PC+4 wraps to zero.
        applyStimulus(1'b1, 2'b11, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1);
        checkOutput("wrap_top", pc, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("wrap_pc", pc, 32'h0);
        checkOutput("wrap_dpc4", dpc4, 32'h0);

        // Enter PENDING, then reset asynchronously in the middle of a cycle.
        applyStimulus(1'b1, 2'b10, 32'h0, 32'h300, 32'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_pc", pc, RESET_PC);
        checkOutput("arst_dvalid", {31'b0, dvalid}, 32'h0);
        checkOutput("arst_dinst", dinst, NOP_INST);
        checkOutput("arst_dpc4", dpc4, 32'h0);
        checkOutput("arst_req", {31'b0, imem_req}, 32'h0);
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("arst_first", pc, 32'h4);
        applyStimulus(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("arst_second", pc, 32'h8);

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            logic        wp;
            logic        rdy;
            logic [1:0]  ps;
            wp  = ($urandom_range(0, 99) < 85);
            rdy = ($urandom_range(0, 99) < 70);
            ps  = ($urandom_range(0, 99) < 70) ? 2'b00 : 2'($urandom_range(1, 3));
            applyStimulus(wp, ps, $urandom, $urandom, $urandom, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
